// File: rtl/norestore_pkg.sv
// Shared widths and helpers for the pipelined non-restoring divider family
// (norestore_cell, norestore_post and the divider top).
package norestore_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned REM_W     = DEF_WIDTH * 3 + 1;
  localparam int unsigned SIGN_BIT  = DEF_WIDTH * 3;

  // Widest divisor the helper below accepts.
  localparam int unsigned MAX_W     = 32;
  localparam int unsigned MAX_REM_W = MAX_W * 3 + 1;

  function automatic int unsigned rem_width(input int unsigned w);
    return w * 3 + 1;
  endfunction

  function automatic int unsigned sign_bit(input int unsigned w);
    return w * 3;
  endfunction

  // Callers cast the argument up to MAX_W and the result down to their own width.
  function automatic logic [MAX_REM_W-1:0] zext_divisor(input logic [MAX_W-1:0] d);
    return MAX_REM_W'(d);
  endfunction

endpackage

// File: rtl/norestore_delay.sv
// DEPTH-stage shift register with async active-low clear; DEPTH=0 is a plain wire.
module norestore_delay
  import norestore_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned DW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout
);

  if (DEPTH == 0) begin : g_wire
    assign o_dout = i_din;
  end else begin : g_sr
    logic [DW-1:0] r_sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else begin
        r_sr[0] <= i_din;
        for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
    end

    assign o_dout = r_sr[DEPTH-1];
  end

endmodule

// File: rtl/norestore_post.sv
// Output stage of the pipelined non-restoring divider: aligns staggered quotient
// taps into one word and applies the final add-back remainder correction.
module norestore_post
  import norestore_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned QWIDTH = 2 * WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [QWIDTH-1:0]     q_tap,
  input  logic [WIDTH*3:0]      remainder_din,
  input  logic [WIDTH-1:0]      divisor_din,
  output logic                  valid_out,
  output logic [QWIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]      remainder,
  output logic                  div_zero
);

  localparam int unsigned L_REM_W = rem_width(WIDTH);
  localparam int unsigned L_SIGN  = sign_bit(WIDTH);

  logic [QWIDTH-1:0]  w_q_aligned;
  logic [L_REM_W-1:0] w_div_ext;
  logic [L_REM_W-1:0] w_corrected;

  // Tap k left its cell k cycles before the final remainder; delay it by k to line up.
  for (genvar k = 0; k < QWIDTH; k++) begin : g_tap
    norestore_delay #(
      .DEPTH (k),
      .DW    (1)
    ) u_delay (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_din  (q_tap[k]),
      .o_dout (w_q_aligned[k])
    );
  end

  assign w_div_ext   = L_REM_W'(zext_divisor(MAX_W'(divisor_din)));
  assign w_corrected = remainder_din[L_SIGN] ? (remainder_din + w_div_ext) : remainder_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      valid_out <= valid_in;
      quotient  <= w_q_aligned;
      remainder <= w_corrected[WIDTH-1:0];
      div_zero  <= valid_in & (divisor_din == '0);
    end
  end

endmodule

// File: doc/norestore_post.md
Name: norestore_post

Overview:
- Output stage placed directly after the last norestore_cell in the pipelined non-restoring divider.
- Collects the staggered quotient bits from all cells and re-times them into one aligned quotient word.
- Applies the final remainder correction: add the divisor back when the last partial remainder is negative.
- Registers the quotient, the corrected remainder, a valid flag and a divide-by-zero flag.

Parameters:
- WIDTH, 4, divisor width; the partial-remainder bus is WIDTH*3+1 bits with the sign at bit 3*WIDTH.
- QWIDTH, 2*WIDTH, number of cells in the chain and quotient width; cell STEP values run QWIDTH-1 down to 0; legal range 1..2*WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  marks remainder_din/divisor_din as the final result of an operation.
- q_tap  input  QWIDTH  q_tap[k] = registered quotient output of the cell with STEP=k.
- remainder_din  input  WIDTH*3+1  registered remainder output of the STEP=0 cell.
- divisor_din  input  WIDTH  divisor pipelined alongside remainder_din (aligned with it).
- valid_out  output  1  result valid.
- quotient  output  QWIDTH  aligned quotient word.
- remainder  output  WIDTH  corrected remainder, always less than the divisor.
- div_zero  output  1  divisor was zero for this result.

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: valid_out, quotient, remainder, div_zero and all delay-line flops go to 0 immediately, independent of clk.
- Timing relation at the input: for an operation whose final remainder appears at cycle N, tap k was valid at cycle N-k.
- Alignment: tap k passes through a k-stage shift register.
  - Tap 0 has zero delay.
  - All delayed taps present bit k for the same operation at cycle N.
- Output register, loaded every cycle (free-running, no stall):
  - quotient[k] <= delayed tap k.
  - valid_out <= valid_in.
  - div_zero <= valid_in & (divisor_din == 0).
- Latency: 1 cycle from remainder_din/valid_in to outputs; k+1 cycles from q_tap[k].
- Throughput: one result per cycle; back-to-back operations must not mix bits. The delay lines shift every cycle regardless of valid_in.
- Correction arithmetic is done at full width WIDTH*3+1, with divisor_din zero-extended:
  - if remainder_din[3*WIDTH] == 1: corrected = remainder_din + divisor.
  - else: corrected = remainder_din.
  - remainder <= corrected[WIDTH-1:0].
  - Upper bits of corrected are zero for any legal input; they are not checked in RTL (assertion only in the bench).
- Quotient needs no correction: each cell's bit is already ~sign of its new partial remainder.
- Divide by zero:
  - quotient and remainder pass through unmodified; no saturation.
  - div_zero=1 for that result only.
- When valid_in=0: outputs still update (data is don't-care) and valid_out=0. Downstream logic qualifies on valid_out.
- Reset mid-operation: in-flight taps are discarded. The first valid_out after reset release occurs only for a valid_in presented after release; the upstream chain also resets.
- No state machine. State is the triangular delay array (QWIDTH*(QWIDTH-1)/2 flops) plus the output register.

Decomposition:
- Shared package norestore_pkg:
  - REM_W = WIDTH*3+1.
  - SIGN_BIT = 3*WIDTH.
  - A function computing the zero-extended divisor.
  - Shared with norestore_cell and the future divider top.
- Sub-module norestore_delay:
  - Parameters DEPTH, DW.
  - DEPTH=0 acts as a wire.
  - Same async active-low reset to 0.
  - Instantiated once per tap inside a generate loop.

Test Plan (WIDTH=4, QWIDTH=8):
- Reset: hold rst_n=0 with random inputs, then release -> all outputs 0; first valid_out only 1 cycle after the first valid_in.
- Negative final remainder: remainder_din=13'h1FFB (-5), divisor_din=7, valid_in=1 -> next cycle remainder=2, valid_out=1, div_zero=0.
- Non-negative final remainder: remainder_din=13'h0002, divisor_din=7 -> remainder=2, no correction applied.
- Alignment, single operation: drive q_tap[k] for 100/7 (quotient 8'h0E), bit k presented at cycle N-k, other cycles' taps at the inverted value -> quotient=8'h0E exactly at valid_out.
- Back-to-back: two operations on consecutive cycles (100/7 then 255/16, quotients 8'h0E and 8'h0F) -> consecutive valid_out with 8'h0E then 8'h0F, no bit crossover.
- Divide by zero and mid-operation reset:
  - divisor_din=0 with valid_in -> div_zero=1 for exactly one cycle.
  - Assert rst_n low while an operation is mid-flight -> outputs clear immediately and no stale valid_out appears after release.
